// File: rtl/bus_width_upsizer.sv
// bus_width_upsizer: packs RATIO narrow words into one wide beat, with early-last zero padding and a keep mask.
module bus_width_upsizer #(
  parameter int IN_W = 8,
  parameter int RATIO = 4,
  parameter int LSB_FIRST = 1,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CNT_W = RATIO > 1 ? $clog2(RATIO) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [RATIO-1:0] out_keep_o,
  output logic             out_last_o
);
  logic [OUT_W-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d, word_data, beat_data;
  logic [RATIO-1:0] acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, word_keep, beat_keep;
  logic [CNT_W-1:0] cnt_q, cnt_d, lane;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d, accept, complete, load;
  // The output register is the only stall point, so the accumulator can always take a word when ready is high.
  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;
  always_comb begin
    lane        = LSB_FIRST != 0 ? cnt_q : CNT_W'(RATIO - 1) - cnt_q;
    word_data   = OUT_W'(in_data_i) << (int'(lane) * IN_W);
    word_keep   = RATIO'(1) << lane;
    beat_data   = acc_data_q | word_data;
    beat_keep   = acc_keep_q | word_keep;
    accept      = in_valid_i && in_ready_o;
    complete    = cnt_q == CNT_W'(RATIO - 1) || in_last_i;
    load        = accept && complete;
    acc_data_d  = !accept ? acc_data_q : complete ? '0 : beat_data;
    acc_keep_d  = !accept ? acc_keep_q : complete ? '0 : beat_keep;
    cnt_d       = !accept ? cnt_q : complete ? '0 : cnt_q + 1'b1;
    out_data_d  = load ? beat_data : out_data_q;
    out_keep_d  = load ? beat_keep : out_keep_q;
    out_last_d  = load ? in_last_i : out_last_q;
    out_valid_d = load ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_bus_width_upsizer.sv
// tb_bus_width_upsizer: four configurations driven from shared inputs, checked against a word-list packing model.
module tb_bus_width_upsizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0, il = 1'b0, ordy = 1'b1;
  logic [7:0] din = 8'h00;
  logic [3:0] ir, ov, ol;
  logic [31:0] od0, od1;
  logic [11:0] od2;
  logic [7:0] od3;
  logic [3:0] ok0, ok1;
  logic [2:0] ok2;
  logic [0:0] ok3;
  logic [31:0] od [4];
  logic [3:0] ok [4];
  int nc = 0, nf = 0;
  int R [4] = '{4, 4, 3, 1};
  int W [4] = '{8, 8, 4, 8};
  int L [4] = '{1, 0, 1, 1};
  logic        m_valid [4];
  logic        m_last [4];
  logic [31:0] m_data [4];
  logic [3:0]  m_keep [4];
  int          m_cnt [4];
  logic [7:0]  m_buf [4][4];

  always #5 clk = ~clk;

  bus_width_upsizer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1)) d0 (.clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir[0]),
    .in_data_i(din), .in_last_i(il), .out_valid_o(ov[0]), .out_ready_i(ordy), .out_data_o(od0), .out_keep_o(ok0), .out_last_o(ol[0]));
  bus_width_upsizer #(.IN_W(8), .RATIO(4), .LSB_FIRST(0)) d1 (.clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir[1]),
    .in_data_i(din), .in_last_i(il), .out_valid_o(ov[1]), .out_ready_i(ordy), .out_data_o(od1), .out_keep_o(ok1), .out_last_o(ol[1]));
  bus_width_upsizer #(.IN_W(4), .RATIO(3), .LSB_FIRST(1)) d2 (.clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir[2]),
    .in_data_i(din[3:0]), .in_last_i(il), .out_valid_o(ov[2]), .out_ready_i(ordy), .out_data_o(od2), .out_keep_o(ok2), .out_last_o(ol[2]));
  bus_width_upsizer #(.IN_W(8), .RATIO(1), .LSB_FIRST(1)) d3 (.clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir[3]),
    .in_data_i(din), .in_last_i(il), .out_valid_o(ov[3]), .out_ready_i(ordy), .out_data_o(od3), .out_keep_o(ok3), .out_last_o(ol[3]));

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = {20'h0, od2};
  assign od[3] = {24'h0, od3};
  assign ok[0] = ok0;
  assign ok[1] = ok1;
  assign ok[2] = {1'b0, ok2};
  assign ok[3] = {3'b0, ok3};

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      m_valid[d] = 1'b0; m_last[d] = 1'b0; m_data[d] = '0; m_keep[d] = '0; m_cnt[d] = 0;
    end
  endtask

  // Collect a packet's words; when RATIO are held or last arrives, place word k in its lane.
  task automatic model_step();
    int lane;
    for (int d = 0; d < 4; d++) begin
      if (iv && (!m_valid[d] || ordy)) begin
        m_buf[d][m_cnt[d]] = (d == 2) ? {4'h0, din[3:0]} : din;
        m_cnt[d]++;
        if (m_cnt[d] == R[d] || il) begin
          m_data[d] = '0;
          m_keep[d] = '0;
          for (int k = 0; k < m_cnt[d]; k++) begin
            lane = L[d] != 0 ? k : R[d] - 1 - k;
            m_data[d] = m_data[d] | (32'(m_buf[d][k]) << (lane * W[d]));
            m_keep[d][lane] = 1'b1;
          end
          m_valid[d] = 1'b1; m_last[d] = il; m_cnt[d] = 0;
        end else if (ordy) m_valid[d] = 1'b0;
      end else if (m_valid[d] && ordy) m_valid[d] = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    iv = v; din = d; il = l; ordy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    iv = 1'b0; il = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ordy = 1'b0;
    model_clear();
    #2;
    for (int d = 0; d < 4; d++) begin
      nc++; if (ov[d] !== 1'b0) begin nf++; $display("FAIL reset_valid d%0d got %b exp 0", d, ov[d]); end
      nc++; if (od[d] !== 32'h0) begin nf++; $display("FAIL reset_data d%0d got %h exp 0", d, od[d]); end
      nc++; if (ok[d] !== 4'h0) begin nf++; $display("FAIL reset_keep d%0d got %h exp 0", d, ok[d]); end
      nc++; if (ol[d] !== 1'b0) begin nf++; $display("FAIL reset_last d%0d got %b exp 0", d, ol[d]); end
      nc++; if (ir[d] !== 1'b1) begin nf++; $display("FAIL reset_ready d%0d got %b exp 1", d, ir[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nc++; if (ir !== 4'hf) begin nf++; $display("FAIL ready_after_reset got %b exp 1111", ir); end
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], i == 3, 1'b1);
      nc++; if (ir[0] !== 1'b1) begin nf++; $display("FAIL lsb_ready word%0d got %b exp 1", i, ir[0]); end
    end
    nc++; if (ov[0] !== 1'b1) begin nf++; $display("FAIL lsb_valid got %b exp 1", ov[0]); end
    nc++; if (od0 !== 32'h44332211) begin nf++; $display("FAIL lsb_data got %h exp 44332211", od0); end
    nc++; if (ok0 !== 4'b1111) begin nf++; $display("FAIL lsb_keep got %b exp 1111", ok0); end
    nc++; if (ol[0] !== 1'b1) begin nf++; $display("FAIL lsb_last got %b exp 1", ol[0]); end
    nc++; if (od1 !== 32'h11223344) begin nf++; $display("FAIL msb_full_data got %h exp 11223344", od1); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_msb_early_last();
    do_reset();
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    drive(1'b1, 8'hBB, 1'b1, 1'b1);
    nc++; if (ov[1] !== 1'b1) begin nf++; $display("FAIL msb_valid got %b exp 1", ov[1]); end
    nc++; if (od1 !== 32'hAABB0000) begin nf++; $display("FAIL msb_data got %h exp aabb0000", od1); end
    nc++; if (ok1 !== 4'b1100) begin nf++; $display("FAIL msb_keep got %b exp 1100", ok1); end
    nc++; if (ol[1] !== 1'b1) begin nf++; $display("FAIL msb_last got %b exp 1", ol[1]); end
    drive(1'b1, 8'h5C, 1'b1, 1'b1);
    nc++; if (od1 !== 32'h5C000000) begin nf++; $display("FAIL msb_restart_data got %h exp 5c000000", od1); end
    nc++; if (ok1 !== 4'b1000) begin nf++; $display("FAIL msb_restart_keep got %b exp 1000", ok1); end
    nc++; if (od0 !== 32'h0000005C || ok0 !== 4'b0001) begin nf++; $display("FAIL lsb_single_lane got %h/%b exp 0000005c/0001", od0, ok0); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic exp_rdy;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      iv = idx < 8; din = 8'(8'h11 * (idx + 1)); il = 1'b0; ordy = c >= 8;
      exp_rdy = c < 4 || c >= 8;
      #1;
      nc++; if (ir[0] !== exp_rdy) begin nf++; $display("FAIL bp_ready cyc%0d got %b exp %b", c, ir[0], exp_rdy); end
      drive(iv, din, 1'b0, ordy);
      if (exp_rdy && idx < 8) idx++;
      if (c >= 3 && c < 8) begin
        nc++; if (ov[0] !== 1'b1 || od0 !== 32'h44332211) begin nf++; $display("FAIL bp_hold cyc%0d got %b/%h exp 1/44332211", c, ov[0], od0); end
      end
      if (c == 8) begin
        nc++; if (ov[0] !== 1'b0) begin nf++; $display("FAIL bp_drain got %b exp 0", ov[0]); end
      end
    end
    nc++; if (ov[0] !== 1'b1 || od0 !== 32'h88776655 || ok0 !== 4'hf || ol[0] !== 1'b0) begin
      nf++; $display("FAIL bp_second got %b/%h/%b/%b exp 1/88776655/1111/0", ov[0], od0, ok0, ol[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_nonpow2();
    logic [11:0] exp [3] = '{12'h321, 12'h654, 12'h987};
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1);
      if (i % 3 == 0) begin
        nc++; if (ov[2] !== 1'b1 || od2 !== exp[i/3-1] || ok2 !== 3'b111 || ol[2] !== 1'b0) begin
          nf++; $display("FAIL np2_beat%0d got %b/%h/%b/%b exp 1/%h/111/0", i / 3, ov[2], od2, ok2, ol[2], exp[i/3-1]);
        end
      end else if (i > 3) begin
        nc++; if (ov[2] !== 1'b0) begin nf++; $display("FAIL np2_gap word%0d got %b exp 0", i, ov[2]); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midbeat();
    do_reset();
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    drive(1'b1, 8'hE2, 1'b0, 1'b0);
    nc++; if (ov[3] !== 1'b1) begin nf++; $display("FAIL mid_pending got %b exp 1", ov[3]); end
    iv = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    #1;
    nc++; if (ov !== 4'h0) begin nf++; $display("FAIL mid_async_valid got %b exp 0000", ov); end
    nc++; if (od3 !== 8'h00 || ir[3] !== 1'b1) begin nf++; $display("FAIL mid_async_clear got %h/%b exp 00/1", od3, ir[3]); end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
    nc++; if (ov[0] !== 1'b1 || od0 !== 32'h04030201 || ok0 !== 4'hf || ol[0] !== 1'b0) begin
      nf++; $display("FAIL mid_next got %b/%h/%b/%b exp 1/04030201/1111/0", ov[0], od0, ok0, ol[0]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_ratio1();
    do_reset();
    drive(1'b1, 8'h5A, 1'b0, 1'b1);
    nc++; if (ov[3] !== 1'b1 || od3 !== 8'h5A || ok3 !== 1'b1 || ol[3] !== 1'b0) begin
      nf++; $display("FAIL r1_first got %b/%h/%b/%b exp 1/5a/1/0", ov[3], od3, ok3, ol[3]);
    end
    drive(1'b1, 8'hC3, 1'b1, 1'b1);
    nc++; if (ov[3] !== 1'b1 || od3 !== 8'hC3 || ok3 !== 1'b1 || ol[3] !== 1'b1) begin
      nf++; $display("FAIL r1_second got %b/%h/%b/%b exp 1/c3/1/1", ov[3], od3, ok3, ol[3]);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    nc++; if (ov[3] !== 1'b0) begin nf++; $display("FAIL r1_idle got %b exp 0", ov[3]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      for (int d = 0; d < 4; d++) begin
        nc++; if (ir[d] !== (!m_valid[d] || ordy)) begin nf++; $display("FAIL rnd_ready d%0d cyc%0d got %b exp %b", d, c, ir[d], !m_valid[d] || ordy); end
        nc++; if (ov[d] !== m_valid[d]) begin nf++; $display("FAIL rnd_valid d%0d cyc%0d got %b exp %b", d, c, ov[d], m_valid[d]); end
        if (m_valid[d]) begin
          nc++; if (od[d] !== m_data[d] || ok[d] !== m_keep[d] || ol[d] !== m_last[d]) begin
            nf++; $display("FAIL rnd_beat d%0d cyc%0d got %h/%b/%b exp %h/%b/%b", d, c, od[d], ok[d], ol[d], m_data[d], m_keep[d], m_last[d]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_early_last();
    test_backpressure();
    test_nonpow2();
    test_reset_midbeat();
    test_ratio1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/bus_width_upsizer.md
# bus_width_upsizer

Parametrised narrow-to-wide bus adapter with packet framing. Packs `RATIO` consecutive `IN_W`-bit words into one `IN_W*RATIO`-bit beat. Supports early packet termination (`in_last`) with zero padding and a per-lane keep mask. Sits between a narrow streaming producer and a wide consumer (FIFO, DMA, wide datapath) and sustains one input word per cycle while the output drains.

## Interface
- `IN_W`, default 8: input word width in bits, ≥1.
- `RATIO`, default 4: input words per output beat, any integer ≥1; power of two not required.
- `LSB_FIRST`, default 1: 1 = first word of a beat lands in the least-significant lane; 0 = most-significant lane.
- Derived: `OUT_W = IN_W*RATIO`; `CNT_W = max(1, $clog2(RATIO))`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  IN_W  input word.
- `in_last`  in  1  word is the final word of its packet.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `out_data`  out  OUT_W  packed beat; unfilled lanes are zero.
- `out_keep`  out  RATIO  bit per lane, 1 = lane holds a real word.
- `out_last`  out  1  beat ends a packet.

## Operation
- Storage: accumulator (`acc_data` OUT_W, `acc_keep` RATIO, lane counter `cnt` CNT_W) and output register (`out_data`, `out_keep`, `out_last`, `out_valid`).
- Input transfer when `in_valid && in_ready`. Output transfer when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. Combinational from `out_ready`; no dependence on `in_valid`/`in_last`.
- Lane k = `cnt` at acceptance. Word goes to bits `[k*IN_W +: IN_W]` and keep bit k if `LSB_FIRST=1`; otherwise lane `RATIO-1-k`.
- Word completes the beat when `cnt == RATIO-1` or `in_last == 1`.
- Non-completing accepted word: write lane, set keep bit, `cnt <= cnt+1`.
- Completing accepted word, at the same edge:
  - Output register loads accumulator contents merged with this word.
  - `out_last <= in_last`; `out_valid <= 1`.
  - Accumulator cleared: data 0, keep 0, `cnt <= 0`.
- Output transfer with no completing word: `out_valid <= 0`. Data/keep/last hold their values (don't-care).
- Simultaneous output transfer and completing word: output reloads, `out_valid` stays 1. No bubble.
- `in_last` on lane `RATIO-1`: full keep mask, `out_last=1`.
- `in_last` on lane 0: keep = single bit, other lanes zero.
- `RATIO=1`: every word completes; block is a registered pipe stage with `out_keep=1`.
- Non-power-of-two `RATIO`: `cnt` never exceeds `RATIO-1`. Values ≥ `RATIO` are unreachable.
- Reset (asynchronous, any time, including mid-beat):
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`.
  - Accumulator cleared, `cnt=0`.
  - `in_ready=1` during and after reset.
  - Partially accumulated words are discarded.
- Consumer-side handshake rule: while `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` are held stable.

## Timing
- Latency: beat visible on `out_valid` the cycle after its completing word is accepted.
- Throughput:
  - With `out_ready` held high, one word per cycle indefinitely.
  - Steady-state output rate of one beat per `RATIO` cycles.
- Backpressure: input stalls only while a completed beat waits. The accumulator never overflows because `in_ready` drops whenever the output register is occupied and not draining.
- Reset release: first word accepted on the first rising edge with `in_valid=1`.

## Test plan
- LSB_FIRST mapping (`IN_W=8`, `RATIO=4`, `LSB_FIRST=1`, `out_ready=1`):
  - Stimulus: words 0x11, 0x22, 0x33, 0x44 back-to-back, `in_last` on 0x44.
  - Response: one cycle after 0x44, `out_data=0x44332211`, `out_keep=4'b1111`, `out_last=1`; `in_ready` never drops.
- MSB_FIRST mapping with early last (same sizes, `LSB_FIRST=0`):
  - Stimulus: 0xAA, then 0xBB with `in_last`.
  - Response: `out_data=0xAABB0000`, `out_keep=4'b1100`, `out_last=1`; the next packet starts at lane 0.
- Backpressure (`out_ready=0` while 8 words are offered continuously):
  - Response: first beat 0x44332211 held stable; `in_ready=0` from the cycle after it appears.
  - Raise `out_ready`: beat accepted; that cycle `in_ready=1` and packing resumes with no word lost or duplicated.
- Non-power-of-two ratio (`RATIO=3`, `IN_W=4`):
  - Stimulus: nine words 0x1…0x9, no `in_last`.
  - Response: beats 0x321, 0x654, 0x987, all `out_keep=3'b111`, `out_last=0`.
- Reset mid-beat:
  - Stimulus: after 2 of 4 words, pulse `rst` asynchronously between edges.
  - Response: `out_valid` and `cnt` go to 0 immediately. The next four words 0x01–0x04 produce exactly 0x04030201.
- `RATIO=1` pass-through:
  - Stimulus: 0x5A, then 0xC3 with `in_last`.
  - Response: each appears one cycle later; `out_keep=1`; `out_last` only on 0xC3.
